lsu_initiator: RTL and testbench
================================

// Module: lsu_initiator
// PURPOSE
//  Load/store initiator sitting between the CPU execute stage and the data-memory responder.
//  Accepts one load/store per handshake and issues a word-aligned, byte-strobed request on the memory bus.
//  Waits for the memory response, then returns aligned, sign/zero-extended load data (or a store ack) to the CPU.
//  Replaces the direct combinational ram hookup so that multi-cycle memories can be attached.
// PARAMETERS
//  ADDR_W          32   address width (CPU and memory side)
//  TIMEOUT_CYCLES  255  cycles in WAIT before timeout error (used only with LSU_TIMEOUT_EN)
// PORTS
//  clk          in   1       system clock, all state on posedge
//  rst          in   1       asynchronous reset, active-high
//  reqValid     in   1       CPU request valid
//  reqReady     out  1       initiator can accept a request (IDLE only)
//  reqWrite     in   1       1 = store, 0 = load
//  reqSize      in   2       0 byte, 1 half, 2 word, 3 illegal
//  reqUnsigned  in   1       load zero-extends when 1, sign-extends when 0
//  reqAddr      in   ADDR_W  byte address
//  reqWdata     in   32      store data, right-justified
//  respValid    out  1       one-cycle pulse: response ready
//  respRdata    out  32      extended load data; 0 for stores and errors
//  respErr      out  1       qualified by respValid: misaligned/illegal size/timeout
//  memReqValid  out  1       bus request valid
//  memReqReady  in   1       responder accepts the request
//  memWE        out  1       bus write enable
//  memAddr      out  ADDR_W  word address ({reqAddr[ADDR_W-1:2],2'b00})
//  memWdata     out  32      store data replicated across lanes
//  memWstrb     out  4       byte-lane strobes (0 for loads)
//  memRespValid in   1       responder completes (read data or write ack)
//  memRdata     in   32      raw read word
// BEHAVIOUR
//  Reset: state IDLE; reqReady=1; respValid=0, respErr=0, respRdata=0; memReqValid=0, memWE=0, memWstrb=0, memAddr=0, memWdata=0.
//  FSM: IDLE -> (reqValid) latch request; goes to ERR if size==3, half with addr[0]!=0, or word with addr[1:0]!=0; else REQ.
//  REQ: memReqValid=1, bus outputs held stable until memReqReady; on handshake -> WAIT.
//  WAIT: memRespValid sampled only here (responder must respond >=1 cycle after handshake); on it -> RESP, latch memRdata.
//  RESP: respValid=1 for exactly one cycle, respErr=0 -> IDLE. ERR: respValid=1, respErr=1, respRdata=0 -> IDLE.
//  Latency (zero-wait memory): accept at T0, memReqValid T1, memRespValid T2, respValid T3. Error path: respValid T1.
//  reqReady=1 only in IDLE; no back-to-back acceptance while RESP/ERR pulses. No respReady: CPU must take the pulse.
//  Store lanes: byte strb=1<<a[1:0], wdata={4{d[7:0]}}; half strb=a[1]?4'b1100:4'b0011, wdata={2{d[15:0]}}; word strb=4'hF.
//  Load extract: byte = memRdata[8*a[1:0]+:8], half = memRdata[16*a[1]+:16]; extend by reqUnsigned; word passthrough.
//  Store completion: WAIT still requires memRespValid; respRdata=0.
//  memRespValid outside WAIT is ignored; memReqReady outside REQ is ignored.
//  Reset mid-operation: immediate return to IDLE and reset values; in-flight bus transaction is abandoned (responder shares rst).
// CONFIGURATION
//  LSU_TIMEOUT_EN defined: counter (8+ bits) cleared on entry to WAIT and incremented each WAIT cycle.
//    Reaching TIMEOUT_CYCLES without memRespValid -> ERR (respErr=1).
//    A memRespValid in the same cycle as the limit wins (normal RESP).
//  LSU_TIMEOUT_EN undefined: no counter; WAIT holds indefinitely.
// STRUCTURE
//  Shared package lsu_pkg: SIZE_B/SIZE_H/SIZE_W/SIZE_X encodings and FSM state encodings (IDLE,REQ,WAIT,RESP,ERR).
//  Sub-module lsu_lane_align (combinational): size+addr[1:0]+data -> memWstrb/memWdata; raw word -> extended load data.
//  FSM, request latch and timeout counter stay in lsu_initiator.
// TESTING
//  1. Store byte, addr=0x8000_0003, wdata=0x0000_00A5 -> memAddr=0x8000_0000, memWstrb=4'b1000, memWdata=0xA5A5_A5A5, respValid, respErr=0.
//  2. Load signed byte, addr=0x8000_0001, memRdata=0x1234_80FF -> respRdata=0xFFFF_FF80; unsigned -> 0x0000_0080.
//  3. Load word, addr=0x8000_0006 -> no memReqValid, respValid at T1 with respErr=1, respRdata=0.
//  4. memReqReady held low 5 cycles -> memReqValid, memAddr, memWdata, memWstrb stable throughout; memRespValid pulsed in REQ ignored.
//  5. rst asserted during WAIT -> all outputs at reset values same cycle; next request completes normally.
//  6. LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4, no memRespValid -> respErr=1 pulse after 4 WAIT cycles; without macro, still waiting at 100 cycles.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store initiator: access sizes, FSM states
// and the alignment legality check used when a request is accepted.
package lsu_pkg;

   typedef enum logic [1:0] {
      SIZE_B = 2'd0,
      SIZE_H = 2'd1,
      SIZE_W = 2'd2,
      SIZE_X = 2'd3
   } lsuSize_e;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      REQ  = 3'd1,
      WAIT = 3'd2,
      RESP = 3'd3,
      ERR  = 3'd4
   } lsuState_e;

   // Misaligned halves/words and the reserved size never reach the bus.
   function automatic logic isIllegal(input logic [1:0] size, input logic [1:0] off);
      case (lsuSize_e'(size))
         SIZE_H:  isIllegal = off[0];
         SIZE_W:  isIllegal = |off;
         SIZE_X:  isIllegal = 1'b1;
         default: isIllegal = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/lsu_initiator_if.sv
// Memory-side request/response bus between the load/store initiator (master)
// and the data-memory responder (slave).
interface lsu_initiator_if #(
   parameter int ADDR_W = 32
);
   logic              memReqValid;
   logic              memReqReady;
   logic              memWE;
   logic [ADDR_W-1:0] memAddr;
   logic [31:0]       memWdata;
   logic [3:0]        memWstrb;
   logic              memRespValid;
   logic [31:0]       memRdata;

   modport master (
      output memReqValid, memWE, memAddr, memWdata, memWstrb,
      input  memReqReady, memRespValid, memRdata
   );

   modport slave (
      input  memReqValid, memWE, memAddr, memWdata, memWstrb,
      output memReqReady, memRespValid, memRdata
   );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: store data/strobes from size+offset, and
// extraction plus sign/zero extension of a raw load word.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [1:0]  stSize,
   input  logic [1:0]  stOff,
   input  logic [31:0] stData,
   output logic [3:0]  stStrb,
   output logic [31:0] stWdata,
   input  logic [1:0]  ldSize,
   input  logic [1:0]  ldOff,
   input  logic        ldUnsigned,
   input  logic [31:0] ldWord,
   output logic [31:0] ldData
);

   logic [7:0]  ldByte;
   logic [15:0] ldHalf;

   always_comb begin
      stStrb  = '0;
      stWdata = '0;
      case (lsuSize_e'(stSize))
         SIZE_B: begin
            stStrb  = 4'b0001 << stOff;
            stWdata = {4{stData[7:0]}};
         end
         SIZE_H: begin
            stStrb  = stOff[1] ? 4'b1100 : 4'b0011;
            stWdata = {2{stData[15:0]}};
         end
         SIZE_W: begin
            stStrb  = 4'hF;
            stWdata = stData;
         end
         default: ;
      endcase
   end

   assign ldByte = ldWord[{ldOff, 3'b000} +: 8];
   assign ldHalf = ldWord[{ldOff[1], 4'b0000} +: 16];

   always_comb begin
      ldData = ldWord;
      case (lsuSize_e'(ldSize))
         SIZE_B:  ldData = ldUnsigned ? {24'b0, ldByte} : {{24{ldByte[7]}}, ldByte};
         SIZE_H:  ldData = ldUnsigned ? {16'b0, ldHalf} : {{16{ldHalf[15]}}, ldHalf};
         default: ;
      endcase
   end

endmodule

// File: rtl/lsu_initiator.sv
// Load/store initiator: CPU request -> aligned memory bus transaction -> extended response.
// Optional WAIT timeout enabled by defining LSU_TIMEOUT_EN.
module lsu_initiator
   import lsu_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              reqValid,
   output logic              reqReady,
   input  logic              reqWrite,
   input  logic [1:0]        reqSize,
   input  logic              reqUnsigned,
   input  logic [ADDR_W-1:0] reqAddr,
   input  logic [31:0]       reqWdata,
   output logic              respValid,
   output logic [31:0]       respRdata,
   output logic              respErr,
   lsu_initiator_if.master   mem
);

   lsuState_e         state, stateNext;
   logic              accept;
   logic              wrQ, unsQ;
   logic [1:0]        sizeQ, offQ;
   logic [ADDR_W-1:0] addrQ;
   logic [31:0]       wdataQ, rdataQ, stWdata, ldData;
   logic [3:0]        strbQ, stStrb;

   assign accept = (state == IDLE) && reqValid;

   lsu_lane_align uLaneAlign (
      .stSize    (reqSize),
      .stOff     (reqAddr[1:0]),
      .stData    (reqWdata),
      .stStrb    (stStrb),
      .stWdata   (stWdata),
      .ldSize    (sizeQ),
      .ldOff     (offQ),
      .ldUnsigned(unsQ),
      .ldWord    (rdataQ),
      .ldData    (ldData)
   );

`ifdef LSU_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   logic [CNT_W-1:0] waitCnt;
   logic             timeoutHit;

   // Counter sits at zero outside WAIT, so it restarts on every WAIT entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         waitCnt <= '0;
      else if (state != WAIT)
         waitCnt <= '0;
      else
         waitCnt <= waitCnt + 1'b1;
   end

   assign timeoutHit = (waitCnt == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         wrQ    <= 1'b0;
         unsQ   <= 1'b0;
         sizeQ  <= '0;
         offQ   <= '0;
         addrQ  <= '0;
         wdataQ <= '0;
         strbQ  <= '0;
         rdataQ <= '0;
      end else begin
         state <= stateNext;
         if (accept) begin
            wrQ    <= reqWrite;
            unsQ   <= reqUnsigned;
            sizeQ  <= reqSize;
            offQ   <= reqAddr[1:0];
            addrQ  <= {reqAddr[ADDR_W-1:2], 2'b00};
            wdataQ <= reqWrite ? stWdata : '0;
            strbQ  <= reqWrite ? stStrb : '0;
         end
         if (state == WAIT && mem.memRespValid)
            rdataQ <= mem.memRdata;
      end
   end

   always_comb begin
      stateNext = state;
      case (state)
         IDLE: if (reqValid) stateNext = isIllegal(reqSize, reqAddr[1:0]) ? ERR : REQ;
         REQ:  if (mem.memReqReady) stateNext = WAIT;
         WAIT: begin
            if (mem.memRespValid)
               stateNext = RESP;
`ifdef LSU_TIMEOUT_EN
            else if (timeoutHit)
               stateNext = ERR;
`endif
         end
         RESP:    stateNext = IDLE;
         ERR:     stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   assign reqReady        = (state == IDLE);
   assign respValid       = (state == RESP) || (state == ERR);
   assign respErr         = (state == ERR);
   assign respRdata       = (state == RESP && !wrQ) ? ldData : '0;
   assign mem.memReqValid = (state == REQ);
   assign mem.memWE       = (state == REQ) && wrQ;
   assign mem.memAddr     = addrQ;
   assign mem.memWdata    = wdataQ;
   assign mem.memWstrb    = strbQ;

endmodule

// File: tb/tb_lsu_initiator.sv
// Scoreboard bench for lsu_initiator; define LSU_TIMEOUT_EN to exercise the timeout build.
module tb_lsu_initiator;
   import lsu_pkg::*;

   localparam int ADDR_W = 32;
`ifdef LSU_TIMEOUT_EN
   localparam int TMO = 4;
`else
   localparam int TMO = 255;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic              reqValid, reqReady, reqWrite, reqUnsigned;
   logic [1:0]        reqSize;
   logic [ADDR_W-1:0] reqAddr;
   logic [31:0]       reqWdata;
   logic              respValid, respErr;
   logic [31:0]       respRdata;

   lsu_initiator_if #(.ADDR_W(ADDR_W)) memBus ();

   lsu_initiator #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO)) dut (
      .clk        (clk),
      .rst        (rst),
      .reqValid   (reqValid),
      .reqReady   (reqReady),
      .reqWrite   (reqWrite),
      .reqSize    (reqSize),
      .reqUnsigned(reqUnsigned),
      .reqAddr    (reqAddr),
      .reqWdata   (reqWdata),
      .respValid  (respValid),
      .respRdata  (respRdata),
      .respErr    (respErr),
      .mem        (memBus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        err;
      logic [31:0] rdata;
   } expResp_t;

   expResp_t sbQ[$];
   int total = 0;
   int bad   = 0;

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic checkResp(input string tag);
      expResp_t e;
      if (sbQ.size() == 0) begin
         checkVal({tag, "_sbEmpty"}, 32'd1, 32'd0);
      end else begin
         e = sbQ.pop_front();
         checkVal({tag, "_respValid"}, {31'b0, respValid}, 32'd1);
         checkVal({tag, "_respErr"}, {31'b0, respErr}, {31'b0, e.err});
         checkVal({tag, "_respRdata"}, respRdata, e.rdata);
      end
   endtask

   task automatic checkResetOutputs(input string tag);
      checkVal({tag, "_reqReady"}, {31'b0, reqReady}, 32'd1);
      checkVal({tag, "_respValid"}, {31'b0, respValid}, 32'd0);
      checkVal({tag, "_respErr"}, {31'b0, respErr}, 32'd0);
      checkVal({tag, "_respRdata"}, respRdata, 32'd0);
      checkVal({tag, "_memReqValid"}, {31'b0, memBus.memReqValid}, 32'd0);
      checkVal({tag, "_memWE"}, {31'b0, memBus.memWE}, 32'd0);
      checkVal({tag, "_memWstrb"}, {28'b0, memBus.memWstrb}, 32'd0);
      checkVal({tag, "_memAddr"}, memBus.memAddr, 32'd0);
      checkVal({tag, "_memWdata"}, memBus.memWdata, 32'd0);
   endtask

   // Presents one request for a single accept edge.
   task automatic issueReq(input string tag, input logic wr, input logic [1:0] sz,
                           input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
      @(negedge clk);
      checkVal({tag, "_reqReady"}, {31'b0, reqReady}, 32'd1);
      reqValid    = 1'b1;
      reqWrite    = wr;
      reqSize     = sz;
      reqUnsigned = uns;
      reqAddr     = addr;
      reqWdata    = wdata;
      @(posedge clk);
      #1 reqValid = 1'b0;
   endtask

   task automatic doOp(input string tag, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rword,
                       input int readyDelay, input logic expErr, input logic [31:0] expRdata,
                       input logic [3:0] expStrb, input logic [31:0] expWdata);
      logic [31:0] expAddr;
      expAddr = {addr[31:2], 2'b00};
      sbQ.push_back({expErr, expRdata});
      issueReq(tag, wr, sz, uns, addr, wdata);
      @(negedge clk);
      if (expErr) begin
         checkVal({tag, "_noMemReq"}, {31'b0, memBus.memReqValid}, 32'd0);
         checkResp(tag);
      end else begin
         checkVal({tag, "_memReqValid"}, {31'b0, memBus.memReqValid}, 32'd1);
         checkVal({tag, "_memAddr"}, memBus.memAddr, expAddr);
         checkVal({tag, "_memWE"}, {31'b0, memBus.memWE}, {31'b0, wr});
         checkVal({tag, "_memWstrb"}, {28'b0, memBus.memWstrb}, {28'b0, expStrb});
         if (wr) checkVal({tag, "_memWdata"}, memBus.memWdata, expWdata);
         for (int i = 0; i < readyDelay; i++) begin
            if (i == 1) begin
               memBus.memRespValid = 1'b1;
               memBus.memRdata     = 32'hDEAD_BEEF;
            end
            @(negedge clk);
            memBus.memRespValid = 1'b0;
            checkVal({tag, "_holdValid"}, {31'b0, memBus.memReqValid}, 32'd1);
            checkVal({tag, "_holdAddr"}, memBus.memAddr, expAddr);
            checkVal({tag, "_holdStrb"}, {28'b0, memBus.memWstrb}, {28'b0, expStrb});
            if (wr) checkVal({tag, "_holdWdata"}, memBus.memWdata, expWdata);
            checkVal({tag, "_holdNoResp"}, {31'b0, respValid}, 32'd0);
         end
         memBus.memReqReady = 1'b1;
         @(posedge clk);
         #1;
         memBus.memReqReady  = 1'b0;
         memBus.memRespValid = 1'b1;
         memBus.memRdata     = rword;
         @(posedge clk);
         #1 memBus.memRespValid = 1'b0;
         @(negedge clk);
         checkResp(tag);
      end
      @(negedge clk);
      checkVal({tag, "_pulseEnd"}, {31'b0, respValid}, 32'd0);
      checkVal({tag, "_readyBack"}, {31'b0, reqReady}, 32'd1);
   endtask

   // Drives a load up to the point where the initiator sits in WAIT.
   task automatic goToWait(input string tag, input logic [31:0] addr);
      issueReq(tag, 1'b0, SIZE_W, 1'b0, addr, 32'd0);
      @(negedge clk);
      memBus.memReqReady = 1'b1;
      @(posedge clk);
      #1 memBus.memReqReady = 1'b0;
   endtask

   initial begin
      int seenAt;
      rst                 = 1'b1;
      reqValid            = 1'b0;
      reqWrite            = 1'b0;
      reqSize             = 2'd0;
      reqUnsigned         = 1'b0;
      reqAddr             = '0;
      reqWdata            = '0;
      memBus.memReqReady  = 1'b0;
      memBus.memRespValid = 1'b0;
      memBus.memRdata     = '0;
      #1;
      checkResetOutputs("reset");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Stores
      doOp("stByte", 1'b1, SIZE_B, 1'b0, 32'h8000_0003, 32'h0000_00A5, 32'h0, 0,
           1'b0, 32'h0, 4'b1000, 32'hA5A5_A5A5);
      doOp("stByte0", 1'b1, SIZE_B, 1'b0, 32'h8000_0100, 32'h1234_5678, 32'h0, 0,
           1'b0, 32'h0, 4'b0001, 32'h7878_7878);
      doOp("stHalfStall", 1'b1, SIZE_H, 1'b0, 32'h8000_0012, 32'h0000_BEEF, 32'h0, 5,
           1'b0, 32'h0, 4'b1100, 32'hBEEF_BEEF);
      doOp("stWord", 1'b1, SIZE_W, 1'b0, 32'h0000_0010, 32'h0123_4567, 32'h0, 0,
           1'b0, 32'h0, 4'hF, 32'h0123_4567);

      // Loads
      doOp("ldByteS", 1'b0, SIZE_B, 1'b0, 32'h8000_0001, 32'h0, 32'h1234_80FF, 0,
           1'b0, 32'hFFFF_FF80, 4'b0, 32'h0);
      doOp("ldByteU", 1'b0, SIZE_B, 1'b1, 32'h8000_0001, 32'h0, 32'h1234_80FF, 0,
           1'b0, 32'h0000_0080, 4'b0, 32'h0);
      doOp("ldByte3", 1'b0, SIZE_B, 1'b0, 32'h8000_0003, 32'h0, 32'h7F00_0000, 0,
           1'b0, 32'h0000_007F, 4'b0, 32'h0);
      doOp("ldByte2", 1'b0, SIZE_B, 1'b0, 32'h8000_0002, 32'h0, 32'h00AB_0000, 2,
           1'b0, 32'hFFFF_FFAB, 4'b0, 32'h0);
      doOp("ldHalfS", 1'b0, SIZE_H, 1'b0, 32'h8000_0002, 32'h0, 32'h8001_1234, 0,
           1'b0, 32'hFFFF_8001, 4'b0, 32'h0);
      doOp("ldHalfU", 1'b0, SIZE_H, 1'b1, 32'h8000_0000, 32'h0, 32'h8001_F234, 0,
           1'b0, 32'h0000_F234, 4'b0, 32'h0);
      doOp("ldHalfS0", 1'b0, SIZE_H, 1'b0, 32'h8000_0000, 32'h0, 32'h0000_F234, 0,
           1'b0, 32'hFFFF_F234, 4'b0, 32'h0);
      doOp("ldWord", 1'b0, SIZE_W, 1'b1, 32'h8000_0004, 32'h0, 32'hCAFE_F00D, 3,
           1'b0, 32'hCAFE_F00D, 4'b0, 32'h0);

      // Error path
      doOp("errWordMis", 1'b0, SIZE_W, 1'b0, 32'h8000_0006, 32'h0, 32'h0, 0,
           1'b1, 32'h0, 4'b0, 32'h0);
      doOp("errHalfMis", 1'b1, SIZE_H, 1'b0, 32'h8000_0001, 32'hFFFF_FFFF, 32'h0, 0,
           1'b1, 32'h0, 4'b0, 32'h0);
      doOp("errSizeX", 1'b0, SIZE_X, 1'b0, 32'h8000_0000, 32'h0, 32'h0, 0,
           1'b1, 32'h0, 4'b0, 32'h0);

      // Reset while waiting for the responder, then recover
      doOp("preRst", 1'b1, SIZE_W, 1'b0, 32'h0000_0040, 32'h5555_AAAA, 32'h0, 0,
           1'b0, 32'h0, 4'hF, 32'h5555_AAAA);
      goToWait("rstWait", 32'h8000_0020);
      #2 rst = 1'b1;
      #1;
      checkResetOutputs("rstMid");
      @(negedge clk);
      rst = 1'b0;
      doOp("postRst", 1'b0, SIZE_B, 1'b1, 32'h8000_0002, 32'h0, 32'h00C3_0000, 0,
           1'b0, 32'h0000_00C3, 4'b0, 32'h0);

      // Responder never answers
      goToWait("noResp", 32'h8000_0030);
      seenAt = 0;
      for (int n = 1; n <= 100; n++) begin
         @(negedge clk);
         if (respValid && seenAt == 0) seenAt = n;
         if (seenAt != 0) break;
      end
`ifdef LSU_TIMEOUT_EN
      checkVal("tmoCycle", seenAt, 32'd5);
      checkVal("tmoErr", {31'b0, respErr}, 32'd1);
      checkVal("tmoRdata", respRdata, 32'd0);
      @(negedge clk);
      checkVal("tmoIdle", {31'b0, reqReady}, 32'd1);
`else
      checkVal("stillWaiting", seenAt, 32'd0);
      checkVal("stillNotReady", {31'b0, reqReady}, 32'd0);
      #2 rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
`endif
      doOp("final", 1'b0, SIZE_W, 1'b0, 32'h8000_0008, 32'h0, 32'h1357_9BDF, 0,
           1'b0, 32'h1357_9BDF, 4'b0, 32'h0);

      checkVal("sbDrained", sbQ.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
